nerv_memarb: RTL and testbench

Single-port memory arbiter for the NERV core. It merges the core's instruction-fetch port, its data port and an external host/loader port onto one synchronous single-port RAM with 1-cycle read latency. It drives the core's `stall` input so that every unstalled cycle sees a valid `imem_data` and `dmem_rdata`. It sits between `nerv` and the on-chip RAM in the SoC top.

---
 rtl/nerv_memarb_pkg.sv | 18 +
 rtl/nerv_memarb.sv | 144 ++++++++++++++
 tb/tb_nerv_memarb.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nerv_memarb_pkg.sv
// Shared types and helpers for the NERV single-port memory arbiter.
package nerv_memarb_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned GAP_W       = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DFETCH  = 2'd1,
    ST_REFETCH = 2'd2
  } state_e;

  // Byte address to full word address; callers truncate to their RAM width.
  function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
    return WORD_ADDR_W'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/nerv_memarb.sv
// Merges NERV fetch, NERV data and a host port onto one 1-cycle-latency
// single-port RAM, stalling the core whenever the fetch slot is taken.
module nerv_memarb
  import nerv_memarb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned HOST_GAP = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              stall,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_data,
  input  logic              dmem_valid,
  input  logic [31:0]       dmem_addr,
  input  logic [3:0]        dmem_wstrb,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [31:0]       host_addr,
  input  logic [3:0]        host_wstrb,
  input  logic [31:0]       host_wdata,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wstrb,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e             r_state;
  logic [ADDR_W-1:0]  r_pend_fetch;
  logic               r_d_is_read;
  logic [31:0]        r_dhold;
  logic               r_h_is_read;
  logic [GAP_W-1:0]   r_gap_cnt;

  state_e             w_state_nxt;
  logic [ADDR_W-1:0]  w_pend_fetch_nxt;
  logic               w_d_is_read_nxt;
  logic [31:0]        w_dhold_nxt;
  logic               w_h_is_read_nxt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic               w_host_grant;
  logic               w_host_rvalid;
  logic [ADDR_W-1:0]  w_ram_addr;
  logic [3:0]         w_ram_wstrb;
  logic [31:0]        w_ram_wdata;
  logic [ADDR_W-1:0]  w_fetch_word;

  assign w_fetch_word = ADDR_W'(word_addr(imem_addr));

  // State register; a reset abandons any pending refetch or load capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pend_fetch <= '0;
      r_d_is_read  <= 1'b0;
      r_dhold      <= '0;
      r_h_is_read  <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_fetch <= w_pend_fetch_nxt;
      r_d_is_read  <= w_d_is_read_nxt;
      r_dhold      <= w_dhold_nxt;
      r_h_is_read  <= w_h_is_read_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
    end
  end

  // Next-state and RAM port steering; priority in RUN is dmem, host, fetch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pend_fetch_nxt = r_pend_fetch;
    w_d_is_read_nxt  = r_d_is_read;
    w_dhold_nxt      = r_dhold;
    w_h_is_read_nxt  = r_h_is_read;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_host_grant     = 1'b0;
    w_host_rvalid    = 1'b0;
    w_ram_addr       = r_pend_fetch;
    w_ram_wstrb      = 4'b0000;
    w_ram_wdata      = '0;

    unique case (r_state)
      ST_RUN: begin
        if (dmem_valid) begin
          w_ram_addr       = ADDR_W'(word_addr(dmem_addr));
          w_ram_wstrb      = dmem_wstrb;
          w_ram_wdata      = dmem_wdata;
          w_pend_fetch_nxt = w_fetch_word;
          w_d_is_read_nxt  = (dmem_wstrb == 4'b0000);
          w_state_nxt      = ST_DFETCH;
        end else if (host_valid && (r_gap_cnt == '0) && !reset) begin
          w_host_grant     = 1'b1;
          w_ram_addr       = ADDR_W'(word_addr(host_addr));
          w_ram_wstrb      = host_wstrb;
          w_ram_wdata      = host_wdata;
          w_pend_fetch_nxt = w_fetch_word;
          w_h_is_read_nxt  = (host_wstrb == 4'b0000);
          w_gap_cnt_nxt    = GAP_W'(HOST_GAP);
          w_state_nxt      = ST_REFETCH;
        end else begin
          w_ram_addr = w_fetch_word;
          if (r_gap_cnt != '0) begin
            w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          end
        end
      end
      ST_DFETCH: begin
        if (r_d_is_read) begin
          w_dhold_nxt = ram_rdata;
        end
        w_state_nxt = ST_RUN;
      end
      ST_REFETCH: begin
        w_host_rvalid = r_h_is_read && !reset;
        w_state_nxt   = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (reset) begin
      w_ram_wstrb = 4'b0000;
    end
  end

  assign stall       = (r_state != ST_RUN) || w_host_grant;
  assign host_ready  = w_host_grant;
  assign host_rvalid = w_host_rvalid;
  assign host_rdata  = ram_rdata;
  assign imem_data   = ram_rdata;
  assign dmem_rdata  = r_dhold;
  assign ram_en      = !reset;
  assign ram_addr    = w_ram_addr;
  assign ram_wstrb   = w_ram_wstrb;
  assign ram_wdata   = w_ram_wdata;

endmodule

// File: tb/tb_nerv_memarb.sv
// Bench for nerv_memarb: directed cycle table plus randomized traffic against
// a schedule-based reference model and a behavioural sync-read RAM.
module tb_nerv_memarb;

  localparam int unsigned AW  = 8;
  localparam int unsigned GAP = 2;
  localparam int unsigned NW  = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic [31:0]   imem_addr, imem_data;
  logic          dmem_valid;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_wstrb;
  logic          host_valid, host_ready, host_rvalid;
  logic [31:0]   host_addr, host_wdata, host_rdata;
  logic [3:0]    host_wstrb;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_wdata, ram_rdata;

  always #5 clock = ~clock;

  nerv_memarb #(.ADDR_W(AW), .HOST_GAP(GAP)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_wstrb(host_wstrb), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM: synchronous read-first, byte strobes.
  logic [31:0] ram [NW];
  always @(posedge clock) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of forced (stalled) cycles scheduled by each access.
  typedef struct {
    logic [AW-1:0] addr;
    bit            cap;
    bit            hrv;
    logic [31:0]   val;
  } sched_t;

  sched_t      sq[$];
  int          gap;
  logic [31:0] m_dhold;
  logic [31:0] shadow [NW];
  bit          prev_rd;
  logic [31:0] prev_data;

  function automatic logic [AW-1:0] wa(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  task automatic model_step();
    sched_t        e;
    logic          e_stall, e_hrdy, e_hrv;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_ws;
    logic [31:0]   e_wd;
    check("dmem_rdata", dmem_rdata, m_dhold);
    if (prev_rd) check("imem_data", imem_data, prev_data);
    if (reset) begin
      check("ram_en_rst", 32'(ram_en), 32'd0);
      check("stall_rst", 32'(stall), 32'(sq.size() != 0));
      check("host_ready_rst", 32'(host_ready), 32'd0);
      check("host_rvalid_rst", 32'(host_rvalid), 32'd0);
      sq.delete();
      gap = 0;
      m_dhold = '0;
      prev_rd = 1'b0;
      return;
    end
    check("ram_en", 32'(ram_en), 32'd1);
    e_hrdy = 1'b0; e_hrv = 1'b0; e_ws = 4'b0000; e_wd = '0;
    if (sq.size() != 0) begin
      e = sq.pop_front();
      e_stall = 1'b1;
      e_addr  = e.addr;
      e_hrv   = e.hrv;
      if (e.hrv) check("host_rdata", host_rdata, e.val);
      if (e.cap) m_dhold = e.val;
    end else if (dmem_valid) begin
      e_stall = 1'b0;
      e_addr  = wa(dmem_addr);
      e_ws    = dmem_wstrb;
      e_wd    = dmem_wdata;
      e.addr = wa(imem_addr); e.cap = (dmem_wstrb == 4'b0000); e.hrv = 1'b0;
      e.val  = shadow[wa(dmem_addr)];
      sq.push_back(e);
    end else if (host_valid && gap == 0) begin
      e_stall = 1'b1;
      e_hrdy  = 1'b1;
      e_addr  = wa(host_addr);
      e_ws    = host_wstrb;
      e_wd    = host_wdata;
      e.addr = wa(imem_addr); e.cap = 1'b0; e.hrv = (host_wstrb == 4'b0000);
      e.val  = shadow[wa(host_addr)];
      sq.push_back(e);
      gap = GAP;
    end else begin
      e_stall = 1'b0;
      e_addr  = wa(imem_addr);
      if (gap > 0) gap--;
    end
    check("stall", 32'(stall), 32'(e_stall));
    check("host_ready", 32'(host_ready), 32'(e_hrdy));
    check("host_rvalid", 32'(host_rvalid), 32'(e_hrv));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wstrb", 32'(ram_wstrb), 32'(e_ws));
    if (e_ws != 4'b0000) check("ram_wdata", ram_wdata, e_wd);
    prev_rd   = (e_ws == 4'b0000);
    prev_data = shadow[e_addr];
    for (int b = 0; b < 4; b++)
      if (e_ws[b]) shadow[e_addr][8*b +: 8] = e_wd[8*b +: 8];
  endtask

  // Directed per-cycle vectors with hand-derived expectations.
  typedef struct {
    logic        rst;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dw;
    logic [31:0] dd;
    logic        hv;
    logic [31:0] ha;
    logic [3:0]  hw;
    logic [31:0] hd;
    logic        e_stall, e_en;
    logic [7:0]  e_addr;
    logic [3:0]  e_ws;
    logic        e_hrdy, e_hrv;
    logic [31:0] e_hrd, e_drd;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic rst, input logic [31:0] ia,
      input logic dv, input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd,
      input logic hv, input logic [31:0] ha, input logic [3:0] hw, input logic [31:0] hd,
      input logic es, input logic een, input logic [7:0] ea, input logic [3:0] ews,
      input logic ehr, input logic ehv, input logic [31:0] ehd, input logic [31:0] edr);
    vec_t v;
    v.rst = rst; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.dd = dd;
    v.hv = hv; v.ha = ha; v.hw = hw; v.hd = hd;
    v.e_stall = es; v.e_en = een; v.e_addr = ea; v.e_ws = ews;
    v.e_hrdy = ehr; v.e_hrv = ehv; v.e_hrd = ehd; v.e_drd = edr;
    vt.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; imem_addr = v.ia;
    dmem_valid = v.dv; dmem_addr = v.da; dmem_wstrb = v.dw; dmem_wdata = v.dd;
    host_valid = v.hv; host_addr = v.ha; host_wstrb = v.hw; host_wdata = v.hd;
  endtask

  vec_t rv;
  bit   h_pend;

  initial begin
    for (int i = 0; i < int'(NW); i++) begin
      ram[i]    = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    ram[8'h40]    = 32'hDEAD_BEEF;
    shadow[8'h40] = 32'hDEAD_BEEF;
    sq.delete(); gap = 0; m_dhold = '0; prev_rd = 1'b0;

    //  rst ia        dv da        dw     dd            hv ha        hw     hd            st en addr   ws     hr hv hrd           drd
    add(1, 32'h00, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 0, 8'h00, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h00, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h00, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h04, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h01, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h08, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h02, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h0C, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h03, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h10, 1, 32'h100, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h40, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h14, 1, 32'h008, 4'hF, 32'hFFFFFFFF, 0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h04, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h14, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h05, 4'h0, 0, 0, 32'h0,        32'hDEADBEEF);
    add(0, 32'h18, 1, 32'h100, 4'h2, 32'h0000AB00, 0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h40, 4'h2, 0, 0, 32'h0,        32'hDEADBEEF);
    add(0, 32'h18, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h06, 4'h0, 0, 0, 32'h0,        32'hDEADBEEF);
    add(0, 32'h1C, 1, 32'h100, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h40, 4'h0, 0, 0, 32'h0,        32'hDEADBEEF);
    add(0, 32'h20, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h07, 4'h0, 0, 0, 32'h0,        32'hDEADBEEF);
    add(0, 32'h20, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h08, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h20, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'hF, 32'h12345678, 1, 1, 8'h80, 4'hF, 1, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h20, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h08, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h24, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        0, 1, 8'h09, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h28, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        0, 1, 8'h0A, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h2C, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        1, 1, 8'h80, 4'h0, 1, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h2C, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h0B, 4'h0, 0, 1, 32'h12345678, 32'hDEADABEF);
    add(0, 32'h2C, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h0B, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h30, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        0, 1, 8'h0C, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h34, 1, 32'h104, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        0, 1, 8'h41, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h38, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        1, 1, 8'h0D, 4'h0, 0, 0, 32'h0,        32'hDEADABEF);
    add(0, 32'h38, 0, 32'h000, 4'h0, 32'h0,        1, 32'h200, 4'h0, 32'h0,        1, 1, 8'h80, 4'h0, 1, 0, 32'h0,        32'h10000041);
    add(0, 32'h38, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h0E, 4'h0, 0, 1, 32'h12345678, 32'h10000041);
    add(0, 32'h38, 0, 32'h000, 4'h0, 32'h0,        1, 32'h204, 4'h1, 32'h000000C3, 0, 1, 8'h0E, 4'h0, 0, 0, 32'h0,        32'h10000041);
    add(0, 32'h3C, 0, 32'h000, 4'h0, 32'h0,        1, 32'h204, 4'h1, 32'h000000C3, 0, 1, 8'h0F, 4'h0, 0, 0, 32'h0,        32'h10000041);
    add(0, 32'h40, 0, 32'h000, 4'h0, 32'h0,        1, 32'h204, 4'h1, 32'h000000C3, 1, 1, 8'h81, 4'h1, 1, 0, 32'h0,        32'h10000041);
    add(0, 32'h40, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 1, 8'h10, 4'h0, 0, 0, 32'h0,        32'h10000041);
    add(0, 32'h44, 1, 32'h100, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h40, 4'h0, 0, 0, 32'h0,        32'h10000041);
    add(1, 32'h48, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0, 32'h0,        32'h10000041);
    add(0, 32'h00, 0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h00, 4'h0, 0, 0, 32'h0,        32'h0);
    add(0, 32'h404,0, 32'h000, 4'h0, 32'h0,        0, 32'h000, 4'h0, 32'h0,        0, 1, 8'h01, 4'h0, 0, 0, 32'h0,        32'h0);

    // Bring the DUT out of its unknown power-up state before checking.
    drive(vt[0]);
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(negedge clock);
      check("tbl_stall", 32'(stall), 32'(vt[i].e_stall));
      check("tbl_ram_en", 32'(ram_en), 32'(vt[i].e_en));
      if (vt[i].e_en) begin
        check("tbl_ram_addr", 32'(ram_addr), 32'(vt[i].e_addr));
        check("tbl_ram_wstrb", 32'(ram_wstrb), 32'(vt[i].e_ws));
      end
      check("tbl_host_ready", 32'(host_ready), 32'(vt[i].e_hrdy));
      check("tbl_host_rvalid", 32'(host_rvalid), 32'(vt[i].e_hrv));
      if (vt[i].e_hrv) check("tbl_host_rdata", host_rdata, vt[i].e_hrd);
      check("tbl_dmem_rdata", dmem_rdata, vt[i].e_drd);
      model_step();
      @(posedge clock);
      #1;
    end

    // Randomized traffic: host holds each request until it is granted.
    h_pend = 1'b0;
    rv = vt[0];
    for (int c = 0; c < 3000; c++) begin
      rv.rst = ($urandom_range(0, 63) == 0);
      rv.ia  = $urandom & 32'hFFFF_FFFC;
      rv.dv  = ($urandom_range(0, 9) < 3);
      rv.da  = $urandom & 32'hFFFF_FFFC;
      rv.dw  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      rv.dd  = $urandom;
      if (!h_pend && $urandom_range(0, 9) < 4) begin
        h_pend = 1'b1;
        rv.ha  = $urandom & 32'hFFFF_FFFC;
        rv.hw  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        rv.hd  = $urandom;
      end
      rv.hv = h_pend;
      drive(rv);
      @(negedge clock);
      model_step();
      if (host_ready) h_pend = 1'b0;
      @(posedge clock);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
